// File: rtl/game_pkg.sv
// Shared constants and state encoding for the score display slice.
package game_pkg;

  localparam int NUM_DIGITS = 5;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern, with a forced-blank input.
module seg7_decode
  import game_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Blank wins over the digit; non-decimal codes also show blank
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = 7'h40;
        4'd1:    o_seg = 7'h79;
        4'd2:    o_seg = 7'h24;
        4'd3:    o_seg = 7'h30;
        4'd4:    o_seg = 7'h19;
        4'd5:    o_seg = 7'h12;
        4'd6:    o_seg = 7'h02;
        4'd7:    o_seg = 7'h78;
        4'd8:    o_seg = 7'h00;
        4'd9:    o_seg = 7'h10;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_seg7_display.sv
// Signed score to six seven-segment digits: sequential double-dabble
// conversion, leading-zero blanking, sign digit and game-over blinking.
module score_seg7_display
  import game_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter bit LZ_BLANK  = 1'b1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score,
  input  logic        game_over,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd_out,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int               CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  // Reset display: "0" in the ones place, everything else dark
  localparam logic [5:0][6:0]  HEX_RST = {{5{SEG_BLANK}}, SEG_ZERO};

  state_t                         r_state;
  state_t                         w_state_next;
  logic                           w_start;
  logic                           w_shift;
  logic                           w_update;
  logic [15:0]                    r_shadow;
  logic [15:0]                    r_mag;
  logic                           r_sign;
  logic [4*NUM_DIGITS-1:0]        r_bcd_work;
  logic [4*NUM_DIGITS-1:0]        w_bcd_adj;
  logic [3:0]                     r_bit_cnt;
  logic                           r_busy;
  logic                           r_done;
  logic [4*NUM_DIGITS-1:0]        r_bcd_out;
  logic [5:0][6:0]                r_hex;
  logic [NUM_DIGITS-1:0][6:0]     w_seg;
  logic [NUM_DIGITS-1:0]          w_lz;
  logic [CNT_W-1:0]               r_blink_cnt;
  logic                           r_blank_phase;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state plus one-hot datapath strobes for the current state
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_update     = 1'b0;
    case (r_state)
      IDLE: begin
        if (score != r_shadow) begin
          w_start      = 1'b1;
          w_state_next = CONVERT;
        end
      end
      CONVERT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == 4'd15) w_state_next = UPDATE;
      end
      UPDATE: begin
        w_update     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Add-3 correction on every digit before each shift, plus the
  // leading-zero mask and segment decode of the finished BCD value.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_bcd_adj[4*gi +: 4] = (r_bcd_work[4*gi +: 4] >= 4'd5) ?
                                  r_bcd_work[4*gi +: 4] + 4'd3 :
                                  r_bcd_work[4*gi +: 4];
    if (gi == 0) begin : g_ones
      assign w_lz[gi] = 1'b0;
    end else begin : g_upper
      assign w_lz[gi] = LZ_BLANK && (r_bcd_work[4*NUM_DIGITS-1:4*gi] == '0);
    end
    seg7_decode u_dec (
      .i_bcd   (r_bcd_work[4*gi +: 4]),
      .i_blank (w_lz[gi]),
      .o_seg   (w_seg[gi])
    );
  end

  // Conversion datapath: capture, shift 16 times, then publish results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow   <= '0;
      r_mag      <= '0;
      r_sign     <= 1'b0;
      r_bcd_work <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd_out  <= '0;
      r_hex      <= HEX_RST;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_shadow   <= score;
        r_sign     <= score[15];
        r_mag      <= score[15] ? (~score + 16'd1) : score;
        r_bcd_work <= '0;
        r_bit_cnt  <= '0;
        r_busy     <= 1'b1;
      end
      if (w_shift) begin
        {r_bcd_work, r_mag} <= {w_bcd_adj, r_mag} << 1;
        r_bit_cnt           <= r_bit_cnt + 4'd1;
      end
      if (w_update) begin
        r_bcd_out <= r_bcd_work;
        r_hex     <= {(r_sign ? SEG_MINUS : SEG_BLANK), w_seg};
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
      end
    end
  end

  // Blink timer: free-runs only while game_over is high, restarts visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blank_phase <= 1'b0;
    end else if (!game_over) begin
      r_blink_cnt   <= '0;
      r_blank_phase <= 1'b0;
    end else if (r_blink_cnt == CNT_MAX) begin
      r_blink_cnt   <= '0;
      r_blank_phase <= ~r_blank_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + CNT_W'(1);
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd_out = r_bcd_out;
  assign HEX0    = r_blank_phase ? SEG_BLANK : r_hex[0];
  assign HEX1    = r_blank_phase ? SEG_BLANK : r_hex[1];
  assign HEX2    = r_blank_phase ? SEG_BLANK : r_hex[2];
  assign HEX3    = r_blank_phase ? SEG_BLANK : r_hex[3];
  assign HEX4    = r_blank_phase ? SEG_BLANK : r_hex[4];
  assign HEX5    = r_blank_phase ? SEG_BLANK : r_hex[5];

endmodule

// File: tb/tb_score_seg7_display.sv
// Randomized self-checking bench for score_seg7_display against a
// decimal-arithmetic reference model.
module tb_score_seg7_display;

  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] score;
  logic        game_over;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_shadow;   // value the model believes the DUT last captured
  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  score_seg7_display #(
    .BLINK_DIV (BLINK_DIV),
    .LZ_BLANK  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .score     (score),
    .game_over (game_over),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int magnitude(input logic [15:0] v);
    return v[15] ? (65536 - int'(v)) : int'(v);
  endfunction

  function automatic logic [19:0] exp_bcd(input logic [15:0] v);
    int          m = magnitude(v);
    int          p = 1;
    logic [19:0] r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_hex(input int k, input logic [15:0] v);
    int m = magnitude(v);
    int p = 1;
    if (k == 5) return v[15] ? 7'h3F : 7'h7F;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && m < p) return 7'h7F;
    return seg_tab[(m / p) % 10];
  endfunction

  function automatic logic [6:0] dut_hex(input int k);
    case (k)
      0:       return HEX0;
      1:       return HEX1;
      2:       return HEX2;
      3:       return HEX3;
      4:       return HEX4;
      default: return HEX5;
    endcase
  endfunction

  task automatic check_display(input string tag, input logic [15:0] v, input bit blank);
    for (int k = 0; k < 6; k++)
      check_value($sformatf("%s HEX%0d", tag, k), 32'(dut_hex(k)),
                  blank ? 32'h7F : 32'(exp_hex(k, v)));
  endtask

  task automatic check_reset(input string tag);
    check_value({tag, " HEX0"}, 32'(HEX0), 32'h40);
    for (int k = 1; k < 6; k++)
      check_value($sformatf("%s HEX%0d", tag, k), 32'(dut_hex(k)), 32'h7F);
    check_value({tag, " bcd_out"}, 32'(bcd_out), 32'h0);
    check_value({tag, " busy"}, 32'(busy), 32'h0);
    check_value({tag, " done"}, 32'(done), 32'h0);
  endtask

  // Drive one value and follow it through conversion; called at a negedge
  task automatic convert_and_check(input logic [15:0] v);
    int    busy_cnt = 0;
    int    done_cnt = 0;
    string tag = $sformatf("conv %04h", v);
    score = v;
    if (v == m_shadow) begin
      repeat (18) begin
        @(posedge clk); @(negedge clk);
        busy_cnt += int'(busy);
        done_cnt += int'(done);
      end
      check_value({tag, " unchanged busy cycles"}, busy_cnt, 0);
      check_value({tag, " unchanged done pulses"}, done_cnt, 0);
      check_value({tag, " bcd_out"}, 32'(bcd_out), 32'(exp_bcd(v)));
      check_display(tag, v, 1'b0);
    end else begin
      for (int i = 0; i <= 17; i++) begin
        @(posedge clk); @(negedge clk);
        if (i < 17) begin
          busy_cnt += int'(busy);
          done_cnt += int'(done);
        end
      end
      check_value({tag, " busy cycles"}, busy_cnt, 17);
      check_value({tag, " early done"}, done_cnt, 0);
      check_value({tag, " done at E0+17"}, 32'(done), 32'h1);
      check_value({tag, " busy at E0+17"}, 32'(busy), 32'h0);
      check_value({tag, " bcd_out"}, 32'(bcd_out), 32'(exp_bcd(v)));
      check_display(tag, v, 1'b0);
      m_shadow = v;
      @(posedge clk); @(negedge clk);
      check_value({tag, " done width"}, 32'(done), 32'h0);
    end
    $display("[TB] conv score=%04h bcd_out=%05h HEX5..0=%02h %02h %02h %02h %02h %02h",
             v, bcd_out, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] dir_vals [10] = '{16'd1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd0,
                                  16'd0, 16'd9, 16'd10000, 16'hD8F0, 16'd100};

  initial begin
    logic [15:0] v;
    int          q_idx[$];
    logic [19:0] q_bcd[$];
    int          cyc;
    int          busy_cnt;
    int          done_cnt;
    bit          blank;

    rst       = 1'b1;
    score     = 16'd0;
    game_over = 1'b0;
    m_shadow  = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    $display("[TB] reset applied");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_value("idle after reset busy", 32'(busy), 32'h0);

    // Directed values including the extremes
    foreach (dir_vals[i]) convert_and_check(dir_vals[i]);

    // Randomized values: small positive, small negative, or full range
    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0:       v = 16'($urandom_range(0, 999));
        1:       v = 16'd0 - 16'($urandom_range(1, 999));
        default: v = 16'($urandom);
      endcase
      convert_and_check(v);
    end

    // Score changes while a conversion is running
    convert_and_check(16'd0);
    score = 16'd5;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 4) score = 16'd7;
      if (done) begin
        q_idx.push_back(i);
        q_bcd.push_back(bcd_out);
      end
    end
    check_value("mid-change done pulses", q_idx.size(), 2);
    check_value("mid-change first done edge", (q_idx.size() > 0) ? q_idx[0] : -1, 17);
    check_value("mid-change first bcd", (q_bcd.size() > 0) ? 32'(q_bcd[0]) : 32'hFFFFFFFF, 32'h5);
    check_value("mid-change second done edge", (q_idx.size() > 1) ? q_idx[1] : -1, 35);
    check_value("mid-change second bcd", (q_bcd.size() > 1) ? 32'(q_bcd[1]) : 32'hFFFFFFFF, 32'h7);
    m_shadow = 16'd7;
    $display("[TB] mid-change: %0d done pulses, final bcd_out=%05h", q_idx.size(), bcd_out);

    // Blinking while game_over is high
    convert_and_check(16'd42);
    game_over = 1'b1;
    check_display("blink n=0", 16'd42, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      blank = ((n / BLINK_DIV) % 2) == 1;
      check_display($sformatf("blink n=%0d", n), 16'd42, blank);
    end
    check_value("blink bcd_out kept", 32'(bcd_out), 32'h42);
    game_over = 1'b0;
    @(posedge clk); @(negedge clk);
    check_display("blink released", 16'd42, 1'b0);
    $display("[TB] blink sequence done, released during blank phase");

    // Reset in the middle of a conversion
    score = 16'd999;
    @(posedge clk); @(negedge clk);
    repeat (7) begin @(posedge clk); @(negedge clk); end
    check_value("pre-reset busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check_reset("mid-conv reset");
    score    = 16'd42;
    busy_cnt = 0;
    done_cnt = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
    end
    check_value("in reset busy cycles", busy_cnt, 0);
    check_value("in reset done pulses", done_cnt, 0);
    rst      = 1'b0;
    m_shadow = 16'd0;
    cyc      = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check_value("post-reset edges to done", cyc, 18);
    check_value("post-reset bcd_out", 32'(bcd_out), 32'h42);
    check_display("post-reset", 16'd42, 1'b0);
    m_shadow = 16'd42;
    $display("[TB] reset mid-conversion, fresh conversion after %0d edges", cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_seg7_display.md
Name: score_seg7_display

Overview:
- Consumes the 16-bit game score produced by the game/scoring logic and the game_over flag.
- Converts the score to signed decimal with a sequential double-dabble engine.
- Drives six active-low seven-segment digits (HEX5..HEX0) on the board.
- Blinks the whole display while game_over is high. Sits beside the display/scoring block at the top level.

Parameters:
- BLINK_DIV, 25000000: clk cycles per blink half-period while game_over is high. Minimum value is 2.
- LZ_BLANK, 1: 1 blanks leading zero digits (HEX0 is never blanked); 0 shows all five digits.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- score  input  16  two's-complement score; may change on any cycle
- game_over  input  1  level; enables blinking
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new digits are latched
- bcd_out  output  20  five BCD digits of |score|; [3:0] is the ones digit
- HEX0..HEX4  output  7 each  digit segments, active-low, bit order {g,f,e,d,c,b,a}
- HEX5  output  7  sign digit: 7'h3F (minus) when the latched value is negative, else 7'h7F

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, shadow=0, busy=0, done=0, bcd_out=0, sign=0.
  - HEX0=7'h40 ("0"); HEX1..HEX5=7'h7F.
  - blink counter=0, blink phase=visible.
- Reset asserted mid-conversion aborts the conversion and restores all of the above.
- State machine: IDLE -> CONVERT -> UPDATE -> IDLE.
- IDLE:
  - If score != shadow at edge E0: shadow<=score, sign<=score[15].
  - mag<=(score[15] ? -score : score), as a 16-bit unsigned value (16'h8000 gives 32768).
  - bcd_work<=0, bit_cnt<=0, state<=CONVERT.
- CONVERT: one iteration per cycle.
  - Each 4-bit digit of bcd_work >= 5 gets +3.
  - Then {bcd_work,mag} is shifted left by 1.
  - bit_cnt increments; after the 16th shift (edge E0+16), state<=UPDATE.
- UPDATE (edge E0+17):
  - bcd_out<=bcd_work; latched sign updates; HEX registers update.
  - done<=1 for exactly one cycle; state<=IDLE.
- busy: registered, high in CONVERT and UPDATE. It goes high after E0 and falls at E0+17.
- Score changes during CONVERT/UPDATE are ignored. The first IDLE cycle then compares against shadow, so the latest value is always converted eventually. Intermediate values may be skipped.
- A new conversion can start on the cycle immediately after UPDATE.
- Segment codes (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Blank=7F.
- Leading-zero blanking (LZ_BLANK=1): digit k (k>=1) is blank when all digits k..4 are zero. Sign digit position is fixed at HEX5.
- Negative zero cannot occur; score=0 always shows HEX5 blank.
- Blink:
  - While game_over=1, the counter runs 0..BLINK_DIV-1; on wrap the phase toggles.
  - In the blank phase, HEX0..HEX5 all output 7'h7F. bcd_out, busy and done are unaffected.
  - When game_over=0: counter<=0, phase<=visible, so digits reappear on the next edge.
  - game_over rising starts the visible phase; the first blank occurs BLINK_DIV cycles later.
- Conversion continues normally while blinking.

Decomposition:
- Shared package (game_pkg): SEG_BLANK=7'h7F, SEG_MINUS=7'h3F, state encoding typedef {IDLE, CONVERT, UPDATE}, digit-count constant NUM_DIGITS=5.
- One sub-module, seg7_decode: combinational 4-bit BCD plus blank-enable to 7-bit active-low segments. Instantiate it five times.

Test Plan:
- Reset: after rst, HEX0=40, HEX1..5=7F, bcd_out=0, busy=0, done=0.
- Positive value:
  - Stimulus: score=1234 from E0.
  - Response: busy=1 for 17 cycles; done pulses after E0+17; bcd_out=20'h01234.
  - HEX3..0=79,24,30,19; HEX4=7F; HEX5=7F.
- Negative and extreme values:
  - score=16'hFFFF -> bcd_out=20'h00001, HEX0=79, HEX1..4=7F, HEX5=3F.
  - score=16'h8000 -> bcd_out=20'h32768, HEX5=3F.
  - score=16'h7FFF -> bcd_out=20'h32767, HEX5=7F.
- Mid-conversion change:
  - Stimulus: score 0->5 at E0, then 5->7 at E0+5.
  - Response: first done shows bcd_out=5; second conversion starts at E0+18; final bcd_out=7 at E0+35. Exactly two done pulses.
- Blink (BLINK_DIV=4):
  - Stimulus: game_over=1 with score=42.
  - Response: HEX alternates 4 cycles visible / 4 cycles all-7F.
  - game_over=0 during the blank phase -> digits visible on the next edge.
- Reset mid-conversion: rst at E0+8 -> outputs return to reset values immediately, and no done pulse occurs.
- With score held at 42 after rst releases, a fresh conversion completes 18 edges later.
